jtdd_gfx_arb: RTL
=================

# jtdd_gfx_arb

Graphics ROM arbiter that shares one SDRAM read port between the character, scroll and object layer fetchers. Each layer presents a ROM address and waits for its `ok` flag. The arbiter keeps a one-word cache per layer, issues SDRAM reads for cache misses in priority order, and returns data with a valid flag. It sits between the layer blocks (e.g. the character layer's `char_addr`/`rom_data`/`rom_ok`) and the SDRAM controller.

## Interface
Parameters:
- `DW`, 16: SDRAM and requester data width.
- `CHAR_AW`, 15: character address width.
- `SCR_AW`, 17: scroll address width.
- `OBJ_AW`, 18: object address width.
- `CHAR_OFFSET`, 22'h00000: SDRAM word base for the character region.
- `SCR_OFFSET`, 22'h08000: SDRAM word base for the scroll region.
- `OBJ_OFFSET`, 22'h28000: SDRAM word base for the object region.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `char_cs`, `scr_cs`, `obj_cs`  in  1 each  requester active.
- `char_addr`  in  CHAR_AW  character ROM address.
- `scr_addr`  in  SCR_AW  scroll ROM address.
- `obj_addr`  in  OBJ_AW  object ROM address.
- `char_data`, `scr_data`, `obj_data`  out  DW each  cached word.
- `char_ok`, `scr_ok`, `obj_ok`  out  1 each  data valid for the current address.
- `sdram_addr`  out  22  word address.
- `sdram_req`  out  1  read request.
- `sdram_ack`  in  1  request accepted, one-cycle pulse.
- `data_rdy`  in  1  `sdram_data` valid, one-cycle pulse.
- `sdram_data`  in  DW  read data.

## Operation
- Per-slot state: `last_addr`, `data`, `valid`.
- A slot is a hit when `valid && addr == last_addr`. `X_ok = X_cs && hit`; this is combinational from registered state and the live address.
- A slot is pending when `X_cs && !hit`.
- FSM:
  - IDLE: if any slot is pending, select a winner, register `issue_addr = addr + OFFSET` (zero-extended to 22 bits, modulo 2^22) and `issue_id`, assert `sdram_req`, go to REQ.
  - REQ: hold `sdram_req` and `sdram_addr` stable until `sdram_ack`. On ack, drop `sdram_req` and go to WAIT.
  - WAIT: on `data_rdy`, write `sdram_data` into slot `issue_id`, set its `last_addr` to the issued requester address, set `valid=1`, go to IDLE.
- `sdram_ack` and `data_rdy` in the same REQ cycle: store the data and go straight to IDLE.
- Fixed priority: char > scr > obj.
- Requester address changes while its read is in flight: the returned data is still stored against the issued address. `ok` stays low because of the mismatch, and the new address is served on a later grant. The read is never aborted.
- `cs` low: the slot keeps its contents and generates no requests. `cs` rising with the same address gives `ok` immediately.
- `data_rdy` in IDLE or REQ (without ack), or `sdram_ack` outside REQ: ignored.
- Slot data is written only on `data_rdy` in the WAIT state, or in the ack+data cycle of REQ.

## Timing
- Reset (async assert, deassert synchronised by the system): state IDLE; `sdram_req=0`, `sdram_addr=0`; all `data=0`, `valid=0`, `last_addr=0`; all `ok=0`.
- Reset asserted mid-transaction aborts the transaction. A `data_rdy` arriving after reset is ignored.
- Miss latency: pending at edge n → `sdram_req` high after edge n+1. Ack at edge a → data_rdy at edge d → `ok` high after edge d.
- Minimum back-to-back issue: one IDLE cycle between transactions.
- `sdram_addr` is constant from the `sdram_req` rise until ack.

## Configuration
- `JTDD_ARB_RR_EN` defined: round-robin grant. The search starts at the slot after the last granted slot, in order char→scr→obj→char. The pointer resets to char, so scr is searched first after reset.
- Not defined: fixed priority char > scr > obj. Obj can starve while char misses continuously.

## Test plan
- Reset then `char_cs=1`, `char_addr=15'h0010`: `sdram_addr=22'h00010`, `sdram_req` held through a 3-cycle ack delay. `data_rdy` with 16'hA55A → `char_ok=1`, `char_data=16'hA55A`. No second request while the address is held.
- `scr_addr=17'h00003` miss: `sdram_addr=22'h08003`. Obj miss on 18'h3FFFF: `sdram_addr=22'h67FFF`.
- Char, scr and obj all miss in the same cycle:
  - Fixed priority: issue order char, scr, obj.
  - `JTDD_ARB_RR_EN`: order scr, obj, char, scr first after reset.
- Change `char_addr` 0x10→0x11 while the 0x10 read is in WAIT: data is stored for 0x10, `char_ok` stays 0, and the next request issues 22'h00011.
- Ack and data_rdy in the same cycle with 16'h1234: stored, FSM back to IDLE, `ok` high the next cycle. Stray `data_rdy` in IDLE: no slot changes.
- Assert `rst_n=0` during WAIT: `sdram_req=0`, all `ok=0` immediately. A late `data_rdy` after release is ignored.

Source files
------------

// File: rtl/jtdd_gfx_arb.sv
// jtdd_gfx_arb: shares one SDRAM read port between the char, scroll and object ROM fetchers
//
// Each layer keeps a one-word cache (last address, data, valid). A layer whose
// live address misses its cache is pending; pending layers are granted one at a
// time and a single SDRAM read is issued per grant. Returned data is always
// stored against the address that was issued, so a requester that moves on
// while its read is in flight simply misses again and is served later.
//
// Build option: define JTDD_ARB_RR_EN for round-robin grant (search starts at
// the slot after the last winner, char->scr->obj->char, pointer resets to char).
// Without it the grant is fixed priority char > scr > obj.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   char_cs/scr_cs/obj_cs            requester active
//   char_addr/scr_addr/obj_addr      requester ROM addresses
//   char_data/scr_data/obj_data      cached word per layer
//   char_ok/scr_ok/obj_ok            cached word matches the live address
//   sdram_addr, sdram_req            read address and request to the SDRAM controller
//   sdram_ack                        request accepted (one-cycle pulse)
//   data_rdy, sdram_data             read data valid (one-cycle pulse) and data
module jtdd_gfx_arb #(
    parameter int          DW          = 16,
    parameter int          CHAR_AW     = 15,
    parameter int          SCR_AW      = 17,
    parameter int          OBJ_AW      = 18,
    parameter logic [21:0] CHAR_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET  = 22'h08000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h28000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               char_cs,
    input  logic               scr_cs,
    input  logic               obj_cs,
    input  logic [CHAR_AW-1:0] char_addr,
    input  logic [SCR_AW-1:0]  scr_addr,
    input  logic [OBJ_AW-1:0]  obj_addr,
    output logic [DW-1:0]      char_data,
    output logic [DW-1:0]      scr_data,
    output logic [DW-1:0]      obj_data,
    output logic               char_ok,
    output logic               scr_ok,
    output logic               obj_ok,
    output logic [21:0]        sdram_addr,
    output logic               sdram_req,
    input  logic               sdram_ack,
    input  logic               data_rdy,
    input  logic [DW-1:0]      sdram_data
);
    // widest requester address, used to carry the issued address back to its slot
    localparam int RAW = (CHAR_AW > SCR_AW) ? ((CHAR_AW > OBJ_AW) ? CHAR_AW : OBJ_AW)
                                            : ((SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t             r_state, w_next;
    logic [CHAR_AW-1:0] r_char_last;
    logic [SCR_AW-1:0]  r_scr_last;
    logic [OBJ_AW-1:0]  r_obj_last;
    logic [DW-1:0]      r_char_data, r_scr_data, r_obj_data;
    logic [2:0]         r_valid;
    logic [21:0]        r_issue_addr;
    logic [1:0]         r_issue_id;
    logic [RAW-1:0]     r_issue_raddr;
    logic [2:0]         w_hit, w_pend;
    logic [1:0]         w_gid;
    logic [RAW-1:0]     w_raddr;
    logic [21:0]        w_off;
    logic               w_store;

    assign w_hit[0] = r_valid[0] && char_addr == r_char_last;
    assign w_hit[1] = r_valid[1] && scr_addr == r_scr_last;
    assign w_hit[2] = r_valid[2] && obj_addr == r_obj_last;
    assign w_pend   = {obj_cs & ~w_hit[2], scr_cs & ~w_hit[1], char_cs & ~w_hit[0]};

`ifdef JTDD_ARB_RR_EN
    logic [1:0] r_ptr;
    // search order rotates so the slot after the last winner is looked at first
    always_comb begin
        w_gid = 2'd0;
        case (r_ptr)
            2'd0:    w_gid = w_pend[1] ? 2'd1 : w_pend[2] ? 2'd2 : 2'd0;
            2'd1:    w_gid = w_pend[2] ? 2'd2 : w_pend[0] ? 2'd0 : 2'd1;
            default: w_gid = w_pend[0] ? 2'd0 : w_pend[1] ? 2'd1 : 2'd2;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 2'd0;
        else if (r_state == ST_IDLE && |w_pend)
            r_ptr <= w_gid;
    end
`else
    assign w_gid = w_pend[0] ? 2'd0 : w_pend[1] ? 2'd1 : 2'd2;
`endif

    assign w_raddr = w_gid == 2'd0 ? RAW'(char_addr) : w_gid == 2'd1 ? RAW'(scr_addr) : RAW'(obj_addr);
    assign w_off   = w_gid == 2'd0 ? CHAR_OFFSET : w_gid == 2'd1 ? SCR_OFFSET : OBJ_OFFSET;

    // ack and data_rdy together in REQ complete the read in one step
    always_comb begin
        w_next  = r_state;
        w_store = 1'b0;
        case (r_state)
            ST_IDLE: w_next = |w_pend ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                w_store = sdram_ack && data_rdy;
                w_next  = !sdram_ack ? ST_REQ : data_rdy ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                w_store = data_rdy;
                w_next  = data_rdy ? ST_IDLE : ST_WAIT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_issue_addr  <= '0;
            r_issue_id    <= '0;
            r_issue_raddr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && |w_pend) begin
                r_issue_addr  <= 22'(w_raddr) + w_off;
                r_issue_id    <= w_gid;
                r_issue_raddr <= w_raddr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_last <= '0;
            r_scr_last  <= '0;
            r_obj_last  <= '0;
            r_char_data <= '0;
            r_scr_data  <= '0;
            r_obj_data  <= '0;
            r_valid     <= '0;
        end else if (w_store) begin
            case (r_issue_id)
                2'd0: begin
                    r_char_last <= r_issue_raddr[CHAR_AW-1:0];
                    r_char_data <= sdram_data;
                    r_valid[0]  <= 1'b1;
                end
                2'd1: begin
                    r_scr_last <= r_issue_raddr[SCR_AW-1:0];
                    r_scr_data <= sdram_data;
                    r_valid[1] <= 1'b1;
                end
                default: begin
                    r_obj_last <= r_issue_raddr[OBJ_AW-1:0];
                    r_obj_data <= sdram_data;
                    r_valid[2] <= 1'b1;
                end
            endcase
        end
    end

    assign sdram_req  = r_state == ST_REQ;
    assign sdram_addr = r_issue_addr;
    assign char_ok    = char_cs && w_hit[0];
    assign scr_ok     = scr_cs && w_hit[1];
    assign obj_ok     = obj_cs && w_hit[2];
    assign char_data  = r_char_data;
    assign scr_data   = r_scr_data;
    assign obj_data   = r_obj_data;
endmodule
